// File: rtl/sdram_init_seq.sv
// sdram_init_seq: SDR SDRAM power-up init sequencer (NOP wait, PRECHARGE ALL, N x AUTO REFRESH, LOAD MODE); define SDRAM_INIT_EMRS_EN to append an extended mode register load
module sdram_init_seq #(
  parameter int          T_PWRUP   = 8000,
  parameter int          T_RP      = 2,
  parameter int          T_RFC     = 6,
  parameter int          T_MRD     = 2,
  parameter int          N_REFRESH = 8,
`ifdef SDRAM_INIT_EMRS_EN
  parameter logic [12:0] EMODE_REG = 13'h000,
`endif
  parameter logic [12:0] MODE_REG  = 13'h022
) (
  input  logic        i_mem_clk,
  input  logic        i_mem_rst_n,
  input  logic        i_sdr_ena,
  output logic        o_cke,
  output logic [3:0]  o_cmd,
  output logic [1:0]  o_ba,
  output logic [12:0] o_addr,
  output logic        o_init_done
);
  localparam logic [15:0] LD_PWRUP = 16'(T_PWRUP - 1);
  localparam logic [15:0] LD_RP    = 16'(T_RP - 1);
  localparam logic [15:0] LD_RFC   = 16'(T_RFC - 1);
  localparam logic [15:0] LD_MRD   = 16'(T_MRD - 1);
  localparam logic [7:0]  NREF     = 8'(N_REFRESH);
  localparam logic [3:0]  C_INH = 4'b1111, C_NOP = 4'b0111, C_PRE = 4'b0010, C_REF = 4'b0001, C_LMR = 4'b0000;
  typedef enum logic [3:0] {
    IDLE, PWRUP, PRE, WAIT_RP, REF, WAIT_RFC, LMR, WAIT_MRD, EMRS, WAIT_EMRD, DONE
  } state_t;
  state_t      state;
  logic [15:0] cnt;
  logic [7:0]  rcnt;
  // sequencer: each command state issues its command for one cycle and loads the wait counter; the next command follows the cycle after it hits zero
  always_ff @(posedge i_mem_clk or negedge i_mem_rst_n) begin
    if (!i_mem_rst_n || !i_sdr_ena) begin
      state       <= IDLE;
      cnt         <= '0;
      rcnt        <= '0;
      o_cke       <= 1'b0;
      o_cmd       <= C_INH;
      o_ba        <= '0;
      o_addr      <= '0;
      o_init_done <= 1'b0;
    end else begin
      o_cke  <= 1'b1;
      o_cmd  <= C_NOP;
      o_ba   <= '0;
      o_addr <= '0;
      cnt    <= cnt - 16'd1;
      case (state)
        IDLE: begin
          state <= PWRUP;
          cnt   <= LD_PWRUP;
        end
        PWRUP:
          if (cnt == '0) begin
            state  <= PRE;
            o_cmd  <= C_PRE;
            o_addr <= 13'h0400;
            cnt    <= LD_RP;
          end
        PRE, WAIT_RP:
          if (cnt == '0) begin
            state <= REF;
            o_cmd <= C_REF;
            cnt   <= LD_RFC;
            rcnt  <= rcnt + 8'd1;
          end else state <= WAIT_RP;
        REF, WAIT_RFC:
          if (cnt != '0) state <= WAIT_RFC;
          else if (rcnt == NREF) begin
            state  <= LMR;
            o_cmd  <= C_LMR;
            o_addr <= MODE_REG;
            cnt    <= LD_MRD;
          end else begin
            state <= REF;
            o_cmd <= C_REF;
            cnt   <= LD_RFC;
            rcnt  <= rcnt + 8'd1;
          end
        LMR, WAIT_MRD:
          if (cnt == '0) begin
`ifdef SDRAM_INIT_EMRS_EN
            state  <= EMRS;
            o_cmd  <= C_LMR;
            o_ba   <= 2'b10;
            o_addr <= EMODE_REG;
            cnt    <= LD_MRD;
`else
            state       <= DONE;
            cnt         <= '0;
            o_init_done <= 1'b1;
`endif
          end else state <= WAIT_MRD;
`ifdef SDRAM_INIT_EMRS_EN
        EMRS, WAIT_EMRD:
          if (cnt == '0) begin
            state       <= DONE;
            cnt         <= '0;
            o_init_done <= 1'b1;
          end else state <= WAIT_EMRD;
`endif
        DONE: begin
          cnt         <= '0;
          o_init_done <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sdram_init_seq.sv
// tb_sdram_init_seq: random enable/reset stimulus checked every cycle against a command-timeline model
module tb_sdram_init_seq;
  localparam int TP = 10, RP = 2, RFC = 6, MRD = 2, NR = 2;
  localparam logic [12:0] MODE = 13'h022;
  localparam int LMR_T = TP + RP + NR * RFC;
`ifdef SDRAM_INIT_EMRS_EN
  localparam int DONE_T = LMR_T + 2 * MRD;
  localparam int N_LMR  = 2;
`else
  localparam int DONE_T = LMR_T + MRD;
  localparam int N_LMR  = 1;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, ena = 1'b0;
  logic        cke, done;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;
  int          errors = 0, checks = 0;
  bit          act = 1'b0;
  int          k = 0;

  always #5 clk = ~clk;

  sdram_init_seq #(.T_PWRUP(TP), .T_RP(RP), .T_RFC(RFC), .T_MRD(MRD), .N_REFRESH(NR), .MODE_REG(MODE)) dut (
    .i_mem_clk(clk), .i_mem_rst_n(rst_n), .i_sdr_ena(ena),
    .o_cke(cke), .o_cmd(cmd), .o_ba(ba), .o_addr(addr), .o_init_done(done));

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask

  // {done, cke, cmd, ba, addr} expected k cycles after the start edge
  function automatic logic [20:0] model_out(input bit a, input int kk);
    logic [3:0]  c = 4'b0111;
    logic [1:0]  b = 2'b00;
    logic [12:0] ad = 13'h0;
    if (!a) return {1'b0, 1'b0, 4'hF, 2'b00, 13'h0};
    if (kk == TP) begin c = 4'b0010; ad = 13'h0400; end
    for (int i = 0; i < NR; i++) if (kk == TP + RP + i * RFC) c = 4'b0001;
    if (kk == LMR_T) begin c = 4'b0000; ad = MODE; end
`ifdef SDRAM_INIT_EMRS_EN
    if (kk == LMR_T + MRD) begin c = 4'b0000; b = 2'b10; ad = 13'h000; end
`endif
    return {kk >= DONE_T, 1'b1, c, b, ad};
  endfunction

  // model time base: k counts edges since the enable was first sampled high
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n || !ena) act = 1'b0;
    else if (!act) begin act = 1'b1; k = 0; end
    else k++;
  end

  initial forever begin
    logic [20:0] e;
    @(negedge clk);
    e = model_out(act, k);
    chk("done", 32'(done), 32'(e[20]));
    chk("cke",  32'(cke),  32'(e[19]));
    chk("cmd",  32'(cmd),  32'(e[18:15]));
    chk("ba",   32'(ba),   32'(e[14:13]));
    chk("addr", 32'(addr), 32'(e[12:0]));
  end

  initial begin
    int npre, nref, nlmr, nbad;
    ena = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("rst_hold_cmd", 32'(cmd), 32'hF);
      chk("rst_hold_cke", 32'(cke), 32'h0);
      chk("rst_hold_done", 32'(done), 32'h0);
    end
    #2 rst_n = 1'b1;
    npre = 0; nref = 0; nlmr = 0; nbad = 0;
    for (int j = 0; j <= 30; j++) begin
      @(negedge clk);
      if (cmd == 4'b0010) npre++;
      if (cmd == 4'b0001) nref++;
      if (cmd == 4'b0000) nlmr++;
      if (cke !== 1'b1) nbad++;
      if (j == 10) begin chk("pre_cmd", 32'(cmd), 32'h2); chk("pre_a10", 32'(addr[10]), 32'h1); end
      if (j == 12 || j == 18) chk("ref_cmd", 32'(cmd), 32'h1);
      if (j == 24) begin
        chk("lmr_cmd", 32'(cmd), 32'h0);
        chk("lmr_addr", 32'(addr), 32'h022);
        chk("lmr_ba", 32'(ba), 32'h0);
      end
`ifdef SDRAM_INIT_EMRS_EN
      if (j == 26) begin
        chk("emrs_cmd", 32'(cmd), 32'h0);
        chk("emrs_ba", 32'(ba), 32'h2);
        chk("emrs_addr", 32'(addr), 32'h0);
      end
      if (j == 27) chk("done_early", 32'(done), 32'h0);
      if (j == 28) chk("done_at", 32'(done), 32'h1);
`else
      if (j == 25) chk("done_early", 32'(done), 32'h0);
      if (j == 26) chk("done_at", 32'(done), 32'h1);
`endif
    end
    chk("count_pre", 32'(npre), 32'd1);
    chk("count_ref", 32'(nref), 32'd2);
    chk("count_lmr", 32'(nlmr), 32'(N_LMR));
    chk("cke_low_cycles", 32'(nbad), 32'd0);
    ena = 1'b0;
    repeat (2) @(negedge clk);
    ena = 1'b1;
    for (int j = 0; j <= 31; j++) begin
      @(negedge clk);
      if (j == 16) begin chk("abort_cmd", 32'(cmd), 32'hF); chk("abort_cke", 32'(cke), 32'h0); end
      if (j == 30) chk("restart_pre", 32'(cmd), 32'h2);
      if (j == 15) ena = 1'b0;
      if (j == 19) ena = 1'b1;
    end
    ena = 1'b0;
    @(negedge clk);
    ena = 1'b1;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_cmd", 32'(cmd), 32'hF);
    chk("async_rst_cke", 32'(cke), 32'h0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      if (j == 10) chk("rst_restart_pre", 32'(cmd), 32'h2);
    end
    repeat (25) begin
      repeat ($urandom_range(0, 40)) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        ena = 1'b0;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        ena = 1'b1;
      end else begin
        #2 rst_n = 1'b0;
        #1 chk("rand_rst_cmd", 32'(cmd), 32'hF);
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    repeat (40) @(negedge clk);
    chk("final_done", 32'(done), 32'h1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
